// File: rtl/regfile_param.sv
// Parametrised 2-read/1-write register file with a post-reset clear engine, zero register and bypass.
// Read latency RD_LAT (0 or 1). Writes are dropped while ready is low, and each drop raises wr_drop for one cycle.
module regfile_param #(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 8,
    parameter int AW       = $clog2(DEPTH),
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    parameter int RD_LAT   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [AW-1:0]    regA,
    input  logic [AW-1:0]    regB,
    input  logic [AW-1:0]    Destreg,
    input  logic [WIDTH-1:0] Data,
    input  logic             en,
    output logic [WIDTH-1:0] contRegA,
    output logic [WIDTH-1:0] contRegB,
    output logic             ready,
    output logic             wr_drop
);

    localparam logic [0:0] CLEAR = 1'b0;
    localparam logic [0:0] RUN   = 1'b1;

    logic [0:0]       state;
    logic [AW-1:0]    ptr;
    logic [WIDTH-1:0] mem [DEPTH];

    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;

    logic [AW-1:0]    raddr   [2];
    logic [WIDTH-1:0] rd_comb [2];

    assign ready = (state == RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLEAR;
            ptr     <= '0;
            wr_drop <= 1'b0;
        end else begin
            wr_drop <= en && !ready;
            if (state == CLEAR) begin
                ptr <= ptr + AW'(1);
                if (ptr == AW'(DEPTH - 1)) begin
                    state <= RUN;
                end
            end
        end
    end

    // The clear engine and writeback share the one array write port.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = Destreg;
        wr_data = Data;
        if (state == CLEAR) begin
            wr_en   = !rst;
            wr_addr = ptr;
            wr_data = '0;
        end else if (en && !rst && !(ZERO_REG != 0 && Destreg == '0)) begin
            wr_en = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign raddr[0] = regA;
    assign raddr[1] = regB;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_comb[p] = mem[raddr[p]];
            if (BYPASS != 0 && en && Destreg == raddr[p]) begin
                rd_comb[p] = Data;
            end
            if (!ready || (ZERO_REG != 0 && raddr[p] == '0)) begin
                rd_comb[p] = '0;
            end
        end
    end

    generate
        if (RD_LAT == 0) begin : g_comb_rd
            assign contRegA = rd_comb[0];
            assign contRegB = rd_comb[1];
        end else begin : g_reg_rd
            always_ff @(posedge clk) begin
                if (rst) begin
                    contRegA <= '0;
                    contRegB <= '0;
                end else begin
                    contRegA <= rd_comb[0];
                    contRegB <= rd_comb[1];
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: three configurations share one stimulus stream, and a queue of expected outputs is checked by a monitor.
module tb_regfile_param;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  regA, regB, Destreg;
    logic [15:0] Data;
    logic        en;
    logic [15:0] ca [3];
    logic [15:0] cb [3];
    logic        rdy [3];
    logic        drp [3];

    int cyc = 0;
    int checks = 0;
    int passed = 0;

    typedef struct {
        int          cyc;
        int          inst;
        int          kind;
        logic [15:0] val;
        string       name;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // u0: defaults, u1: no zero reg / no bypass, u2: registered read
    regfile_param #(.WIDTH(16), .DEPTH(8), .ZERO_REG(1), .BYPASS(1), .RD_LAT(0)) u0 (
        .clk(clk), .rst(rst), .regA(regA), .regB(regB), .Destreg(Destreg), .Data(Data),
        .en(en), .contRegA(ca[0]), .contRegB(cb[0]), .ready(rdy[0]), .wr_drop(drp[0]));
    regfile_param #(.WIDTH(16), .DEPTH(8), .ZERO_REG(0), .BYPASS(0), .RD_LAT(0)) u1 (
        .clk(clk), .rst(rst), .regA(regA), .regB(regB), .Destreg(Destreg), .Data(Data),
        .en(en), .contRegA(ca[1]), .contRegB(cb[1]), .ready(rdy[1]), .wr_drop(drp[1]));
    regfile_param #(.WIDTH(16), .DEPTH(8), .ZERO_REG(1), .BYPASS(1), .RD_LAT(1)) u2 (
        .clk(clk), .rst(rst), .regA(regA), .regB(regB), .Destreg(Destreg), .Data(Data),
        .en(en), .contRegA(ca[2]), .contRegB(cb[2]), .ready(rdy[2]), .wr_drop(drp[2]));

    function automatic logic [15:0] actual(input int inst, input int kind);
        case (kind)
            0:       return ca[inst];
            1:       return cb[inst];
            2:       return {15'b0, rdy[inst]};
            default: return {15'b0, drp[inst]};
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_at(input int c, input int inst, input int kind, input logic [15:0] v, input string nm);
        exp_t e;
        e.cyc  = c;
        e.inst = inst;
        e.kind = kind;
        e.val  = v;
        e.name = nm;
        q.push_back(e);
    endtask

    task automatic rd_exp(input int c, input int inst, input logic [15:0] a, input logic [15:0] b, input string nm);
        expect_at(c, inst, 0, a, {nm, "_A"});
        expect_at(c, inst, 1, b, {nm, "_B"});
    endtask

    task automatic ready_all(input logic v, input string nm);
        for (int k = 0; k < 3; k++) expect_at(cyc, k, 2, {15'b0, v}, nm);
    endtask

    always @(negedge clk) begin : monitor
        exp_t        keep[$];
        logic [15:0] act;
        keep = {};
        foreach (q[i]) begin
            if (q[i].cyc <= cyc) begin
                act = actual(q[i].inst, q[i].kind);
                checks++;
                if (q[i].cyc == cyc && act === q[i].val) begin
                    passed++;
                end else begin
                    $display("FAIL %s: u%0d cycle %0d got %h expected %h (due cycle %0d)",
                             q[i].name, q[i].inst, cyc, act, q[i].val, q[i].cyc);
                end
            end else begin
                keep.push_back(q[i]);
            end
        end
        q = keep;
    end

    initial begin
        rst = 1'b1; en = 1'b0; regA = '0; regB = '0; Destreg = '0; Data = '0;
        repeat (2) step();
        rst = 1'b0;

        // Clear sequence; write in clear cycle 2 must be dropped.
        for (int i = 0; i < 8; i++) begin
            if (i > 0) step();
            en = (i == 2); Destreg = 3'd3; Data = 16'hBEEF; regA = 3'd3; regB = 3'd3;
            ready_all(1'b0, "clr_ready");
            if (i == 0) begin
                for (int k = 0; k < 3; k++) begin
                    expect_at(cyc, k, 3, 16'h0, "rst_drop");
                    rd_exp(cyc, k, 16'h0, 16'h0, "rst_rd");
                end
            end
            if (i == 3) for (int k = 0; k < 3; k++) expect_at(cyc, k, 3, 16'h1, "drop_pulse");
            if (i == 4) for (int k = 0; k < 3; k++) expect_at(cyc, k, 3, 16'h0, "drop_end");
        end
        step();
        en = 1'b0;
        ready_all(1'b1, "ready_up");
        rd_exp(cyc, 0, 16'h0, 16'h0, "reg3_dropped");
        rd_exp(cyc, 1, 16'h0, 16'h0, "reg3_dropped");
        rd_exp(cyc + 1, 2, 16'h0, 16'h0, "reg3_dropped");

        // Basic write/read
        step(); en = 1'b1; Destreg = 3'd5; Data = 16'h1234;
        step(); Destreg = 3'd6; Data = 16'h00FF;
        step(); en = 1'b0; regA = 3'd5; regB = 3'd6;
        rd_exp(cyc, 0, 16'h1234, 16'h00FF, "basic");
        rd_exp(cyc, 1, 16'h1234, 16'h00FF, "basic");
        rd_exp(cyc + 1, 2, 16'h1234, 16'h00FF, "rdlat_basic");

        // Zero register
        step(); en = 1'b1; Destreg = 3'd0; Data = 16'hFFFF; regA = 3'd0; regB = 3'd0;
        rd_exp(cyc, 0, 16'h0, 16'h0, "zero_wr_cycle");
        rd_exp(cyc, 1, 16'h0, 16'h0, "nozero_wr_cycle");
        step(); en = 1'b0;
        rd_exp(cyc, 0, 16'h0, 16'h0, "zero_reg");
        rd_exp(cyc, 1, 16'hFFFF, 16'hFFFF, "nozero_reg");
        rd_exp(cyc, 2, 16'h0, 16'h0, "rdlat_zero");
        expect_at(cyc, 0, 3, 16'h0, "zero_no_drop");

        // Bypass
        step(); en = 1'b1; Destreg = 3'd2; Data = 16'h0001;
        rd_exp(cyc, 2, 16'h0, 16'h0, "rdlat_zero2");
        step(); Data = 16'h0A0A; regA = 3'd2; regB = 3'd2;
        rd_exp(cyc, 0, 16'h0A0A, 16'h0A0A, "bypass");
        rd_exp(cyc, 1, 16'h0001, 16'h0001, "nobypass_old");
        rd_exp(cyc + 1, 2, 16'h0A0A, 16'h0A0A, "rdlat_bypass");
        step(); en = 1'b0;
        rd_exp(cyc, 0, 16'h0A0A, 16'h0A0A, "bypass_held");
        rd_exp(cyc, 1, 16'h0A0A, 16'h0A0A, "nobypass_new");

        // Registered read with bypass
        step(); en = 1'b1; Destreg = 3'd5; Data = 16'h5555; regA = 3'd5; regB = 3'd6;
        rd_exp(cyc, 0, 16'h5555, 16'h00FF, "bypass5");
        rd_exp(cyc, 1, 16'h1234, 16'h00FF, "nobypass5");
        rd_exp(cyc + 1, 2, 16'h5555, 16'h00FF, "rdlat_bypass5");
        step(); en = 1'b0;
        expect_at(cyc, 1, 0, 16'h5555, "nobypass5_new");

        // Fill every register, then reset from RUN
        for (int i = 0; i < 8; i++) begin
            step(); en = 1'b1; Destreg = 3'(i); Data = 16'h1000 + 16'(i);
        end
        step(); en = 1'b0; regA = 3'd7; regB = 3'd1;
        rd_exp(cyc, 0, 16'h1007, 16'h1001, "fill");
        rd_exp(cyc, 1, 16'h1007, 16'h1001, "fill");
        step(); rst = 1'b1;
        step(); rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) step();
            rst = (i == 4);
            ready_all(1'b0, "run_rst_ready");
            if (i == 0) begin
                rd_exp(cyc, 0, 16'h0, 16'h0, "rd_forced0");
                rd_exp(cyc, 1, 16'h0, 16'h0, "rd_forced0");
                rd_exp(cyc, 2, 16'h0, 16'h0, "rdlat_rst");
            end
        end

        // Reset landed in clear cycle 4: clear restarts from 0
        for (int i = 0; i < 8; i++) begin
            step();
            rst = 1'b0;
            ready_all(1'b0, "midclr_ready");
        end
        step();
        ready_all(1'b1, "midclr_ready_up");
        for (int i = 0; i < 8; i++) begin
            if (i > 0) step();
            regA = 3'(i); regB = 3'(7 - i);
            rd_exp(cyc, 0, 16'h0, 16'h0, "post_clear");
            rd_exp(cyc, 1, 16'h0, 16'h0, "post_clear");
            rd_exp(cyc + 1, 2, 16'h0, 16'h0, "post_clear");
        end

        for (int n = 0; n < 10 && q.size() > 0; n++) begin
            @(negedge clk);
            #1;
        end
        if (q.size() > 0) begin
            checks++;
            $display("FAIL drain: %0d expectations still pending, required 0", q.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
